// File: rtl/led_pkg.sv
// Shared LED driver constants: LED count, default PWM width and breathing-envelope state encoding.
package led_pkg;
  localparam int LED_COUNT    = 4;
  localparam int LED_PWM_BITS = 8;

  typedef enum logic {
    ENV_RISE = 1'b0,
    ENV_FALL = 1'b1
  } env_state_t;
endpackage

// File: rtl/led_breath_env.sv
// Breathing envelope: triangle ramp 0..max..0, one step every STEP_PERIODS period ticks.
// Held at 0 in RISE while disabled; no backpressure, env is a plain registered level.
module led_breath_env
  import led_pkg::*;
#(
  parameter int PWM_BITS     = LED_PWM_BITS,
  parameter int STEP_PERIODS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                period_tick,
  input  logic                enable,
  output logic [PWM_BITS-1:0] env
);

  localparam logic [PWM_BITS-1:0] ENV_MAX   = '1;
  localparam logic [PWM_BITS-1:0] ENV_ONE   = PWM_BITS'(1);
  localparam logic [15:0]         STEP_LAST = 16'(STEP_PERIODS - 1);

  env_state_t          state, state_nxt;
  logic [PWM_BITS-1:0] env_nxt;
  logic [15:0]         step_cnt, step_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ENV_RISE;
      env      <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      env      <= env_nxt;
      step_cnt <= step_cnt_nxt;
    end
  end

  // Direction flips on the step that lands on an endpoint, so each endpoint lasts exactly one step.
  always_comb begin
    state_nxt    = state;
    env_nxt      = env;
    step_cnt_nxt = step_cnt;
    if (!enable) begin
      state_nxt    = ENV_RISE;
      env_nxt      = '0;
      step_cnt_nxt = '0;
    end else if (period_tick) begin
      if (step_cnt != STEP_LAST) begin
        step_cnt_nxt = step_cnt + 16'd1;
      end else begin
        step_cnt_nxt = '0;
        case (state)
          ENV_RISE: begin
            env_nxt = env + ENV_ONE;
            if (env == ENV_MAX - ENV_ONE) state_nxt = ENV_FALL;
          end
          ENV_FALL: begin
            env_nxt = env - ENV_ONE;
            if (env == ENV_ONE) state_nxt = ENV_RISE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// 4-LED PWM driver; pattern/brightness/breathing changes apply only at period boundaries. No backpressure.
// led_out lags cnt by 1 clk; with LED_PWM_GAMMA_EN defined, duty is gamma-squared and latency is 2 clk.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int CLK_FREQ     = 200_000_000,
  parameter int PWM_BITS     = LED_PWM_BITS,
  parameter int STEP_PERIODS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LED_COUNT-1:0] pat_in,
  input  logic                 pat_valid,
  input  logic [PWM_BITS-1:0]  bright,
  input  logic                 breathe_en,
  output logic [LED_COUNT-1:0] led_out,
  output logic                 pwm_sync
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);

  if (STEP_PERIODS < 1 || STEP_PERIODS > 65535 || CLK_FREQ < 1) begin : g_bad_param
    $error("led_pwm_driver: STEP_PERIODS or CLK_FREQ out of range");
  end

  logic [PWM_BITS-1:0]   cnt;
  logic                  period_end;
  logic [LED_COUNT-1:0]  pend_pat;
  logic [LED_COUNT-1:0]  active_pat;
  logic [PWM_BITS-1:0]   active_bright;
  logic                  active_breathe;
  logic [PWM_BITS-1:0]   env;
  logic [2*PWM_BITS-1:0] scaled;
  logic [PWM_BITS-1:0]   duty;

  assign period_end = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      pwm_sync       <= 1'b0;
      pend_pat       <= '0;
      active_pat     <= '0;
      active_bright  <= '0;
      active_breathe <= 1'b0;
    end else begin
      cnt      <= cnt + CNT_ONE;
      pwm_sync <= period_end;
      if (pat_valid) pend_pat <= pat_in;
      // A strobe landing on the last count bypasses pending so it is not lost for a period.
      if (period_end) begin
        active_pat     <= pat_valid ? pat_in : pend_pat;
        active_bright  <= bright;
        active_breathe <= breathe_en;
      end
    end
  end

  led_breath_env #(
    .PWM_BITS    (PWM_BITS),
    .STEP_PERIODS(STEP_PERIODS)
  ) u_env (
    .clk        (clk),
    .rst        (rst),
    .period_tick(period_end),
    .enable     (active_breathe),
    .env        (env)
  );

  assign scaled = {{PWM_BITS{1'b0}}, active_bright} * {{PWM_BITS{1'b0}}, env};
  assign duty   = active_breathe ? PWM_BITS'(scaled >> PWM_BITS) : active_bright;

`ifdef LED_PWM_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;
  logic [PWM_BITS-1:0]   g_cnt;
  logic [PWM_BITS-1:0]   g_duty;
  logic [LED_COUNT-1:0]  g_pat;

  assign duty_sq = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};

  // cnt and pattern ride along with the squared duty so the compare stays period-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_cnt   <= '0;
      g_duty  <= '0;
      g_pat   <= '0;
      led_out <= '0;
    end else begin
      g_cnt   <= cnt;
      g_duty  <= PWM_BITS'(duty_sq >> PWM_BITS);
      g_pat   <= active_pat;
      led_out <= g_pat & {LED_COUNT{g_cnt < g_duty}};
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_out <= '0;
    else     led_out <= active_pat & {LED_COUNT{cnt < duty}};
  end
`endif

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: per-period expected waveforms queued at stimulus time, compared as periods complete.
// A second 4-bit instance covers the full breathing triangle including both turnarounds.
module tb_led_pwm_driver;

  localparam int NB = 8;
  localparam int NP = 256;
  localparam int SB = 4;
  localparam int SP = 16;
  localparam int S_PERIODS = 36;
`ifdef LED_PWM_GAMMA_EN
  localparam int LAT   = 2;
  localparam bit GAMMA = 1'b1;
`else
  localparam int LAT   = 1;
  localparam bit GAMMA = 1'b0;
`endif

  typedef logic [3:0][255:0] wave_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    pat_in;
  logic          pat_valid;
  logic [NB-1:0] bright;
  logic          breathe_en;
  logic [3:0]    led_out;
  logic          pwm_sync;

  logic          s_rst = 1'b0;
  logic [3:0]    s_pat_in;
  logic          s_pat_valid;
  logic [SB-1:0] s_bright;
  logic          s_breathe;
  logic [3:0]    s_led;
  logic          s_sync;

  int         total = 0;
  int         bad = 0;
  int         tb_cyc = 0;
  int         s_cyc = 0;
  int         bj = 0;
  int         s_sync_err = 0;
  bit         s_done = 1'b0;
  logic [3:0] exp_pend;
  wave_t      sb[$];
  int         s_q[$];

  initial forever #5 clk = ~clk;

  led_pwm_driver #(.STEP_PERIODS(1)) dut (
    .clk(clk), .rst(rst), .pat_in(pat_in), .pat_valid(pat_valid), .bright(bright),
    .breathe_en(breathe_en), .led_out(led_out), .pwm_sync(pwm_sync)
  );

  led_pwm_driver #(.PWM_BITS(SB), .STEP_PERIODS(1)) dut_s (
    .clk(clk), .rst(s_rst), .pat_in(s_pat_in), .pat_valid(s_pat_valid), .bright(s_bright),
    .breathe_en(s_breathe), .led_out(s_led), .pwm_sync(s_sync)
  );

  task automatic chk_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic int tri_env(input int j, input int bits);
    int mx, m;
    mx = (1 << bits) - 1;
    m  = j % (2 * mx);
    return (m <= mx) ? m : 2 * mx - m;
  endfunction

  function automatic int eff_duty(input int br, input int env, input bit breathe, input int bits);
    int d;
    d = breathe ? (br * env) >> bits : br;
    if (GAMMA) d = (d * d) >> bits;
    return d;
  endfunction

  function automatic wave_t mk_wave(input logic [3:0] p, input int duty);
    wave_t w;
    w = '0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < NP; k++)
        w[i][k] = p[i] && (k < duty);
    return w;
  endfunction

  // Cycle counter plus expected-waveform producer for the period that starts after this edge.
  initial begin : sb_push
    int d;
    forever begin
      @(posedge clk);
      if (rst) tb_cyc = 0;
      else begin
        if (tb_cyc % NP == NP - 1) begin
          if (breathe_en) begin
            d = eff_duty(int'(bright), tri_env(bj, NB), 1'b1, NB);
            bj++;
          end else begin
            d = eff_duty(int'(bright), 0, 1'b0, NB);
            bj = 0;
          end
          sb.push_back(mk_wave(exp_pend, d));
        end
        tb_cyc++;
      end
    end
  end

  initial begin : mon
    logic [255:0] sync_obs;
    wave_t obs, e;
    int k, pos;
    sync_obs = '0;
    obs = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sync_obs = '0;
        obs = '0;
      end else begin
        k = tb_cyc % NP;
        sync_obs[k] = pwm_sync;
        if (k == NP - 1) chk_eq($sformatf("sync_p%0d", tb_cyc / NP), sync_obs, 256'(tb_cyc / NP == 0 ? 0 : 1));
        pos = tb_cyc - LAT;
        if (pos >= 0) begin
          k = pos % NP;
          for (int i = 0; i < 4; i++) obs[i][k] = led_out[i];
          if (k == NP - 1) begin
            if (sb.size() == 0) chk_eq("sb_empty", 256'd1, 256'd0);
            else begin
              e = sb.pop_front();
              for (int i = 0; i < 4; i++) chk_eq($sformatf("wave%0d_p%0d", i, pos / NP), obs[i], e[i]);
            end
          end
        end
      end
    end
  end

  task automatic at(input int cyc);
    int guard;
    guard = 0;
    while (tb_cyc != cyc && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (tb_cyc != cyc) chk_eq("at_timeout", 256'(tb_cyc), 256'(cyc));
  endtask

  task automatic pulse(input logic [3:0] p, input int cyc);
    at(cyc);
    pat_in    = p;
    pat_valid = 1'b1;
    exp_pend  = p;
    @(negedge clk);
    pat_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    pat_valid = 1'b0;
    #1;
    chk_eq("rst_led_now", 256'(led_out), 256'd0);
    chk_eq("rst_sync_now", 256'(pwm_sync), 256'd0);
    repeat (cycles) begin
      @(negedge clk);
      chk_eq("rst_led", 256'(led_out), 256'd0);
      chk_eq("rst_sync", 256'(pwm_sync), 256'd0);
    end
    #2;
    rst = 1'b0;
    sb.delete();
    sb.push_back('0);
    exp_pend = '0;
    bj = 0;
    #1;
    chk_eq("rel_led", 256'(led_out), 256'd0);
    chk_eq("rel_sync", 256'(pwm_sync), 256'd0);
  endtask

  initial begin : main
    int guard;
    pat_in = '0; pat_valid = 1'b0; bright = 8'd128; breathe_en = 1'b0; exp_pend = '0;
    do_reset(3);
    pulse(4'b0001, 10);
    pulse(4'b0010, 2 * NP + 100);
    pulse(4'b0100, 3 * NP + 20);
    pulse(4'b1000, 3 * NP + 200);
    pulse(4'b0011, 4 * NP + 255);
    at(5 * NP + 30);  bright = 8'd0;
    at(6 * NP + 30);  bright = 8'd255;
    at(7 * NP + 30);  breathe_en = 1'b1;
    at(11 * NP + 30); breathe_en = 1'b0;
    at(12 * NP + 30); breathe_en = 1'b1;
    at(15 * NP + 30); breathe_en = 1'b0;
    at(16 * NP + 50);
    chk_eq("pre_rst_lit", 256'(led_out), 256'(4'b0011));
    do_reset(3);
    pulse(4'b0100, NP + 60);
    at(3 * NP + LAT + 2);
    guard = 0;
    while (!s_done && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk_eq("s_done", 256'(s_done), 256'd1);
    chk_eq("s_sync", 256'(s_sync_err), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial forever begin
    @(posedge clk);
    if (s_rst) s_cyc = 0;
    else s_cyc++;
  end

  initial begin : s_stim
    s_pat_in = 4'b0001; s_pat_valid = 1'b0; s_bright = 4'd15; s_breathe = 1'b1;
    s_rst = 1'b1;
    for (int p = 0; p < S_PERIODS; p++)
      s_q.push_back(p == 0 ? 0 : eff_duty(15, tri_env(p - 1, SB), 1'b1, SB));
    repeat (3) @(negedge clk);
    #2 s_rst = 1'b0;
    repeat (3) @(negedge clk);
    s_pat_valid = 1'b1;
    @(negedge clk);
    s_pat_valid = 1'b0;
  end

  initial begin : s_mon
    int acc, stray, pos, k, e;
    acc = 0; stray = 0;
    forever begin
      @(negedge clk);
      if (!s_rst) begin
        s_sync_err += int'(s_sync != (s_cyc >= SP && s_cyc % SP == 0));
        pos = s_cyc - LAT;
        if (pos >= 0 && s_q.size() > 0) begin
          k = pos % SP;
          if (k == 0) begin
            acc = 0;
            stray = 0;
          end
          acc += int'(s_led[0]);
          stray += int'(s_led[3:1] != 3'b000);
          if (k == SP - 1) begin
            e = s_q.pop_front();
            chk_eq($sformatf("env_p%0d", pos / SP), 256'(acc), 256'(e));
            chk_eq($sformatf("env_stray_p%0d", pos / SP), 256'(stray), 256'd0);
            if (s_q.size() == 0) s_done = 1'b1;
          end
        end
      end
    end
  end

endmodule
